// File: rtl/regfile_wb_if.sv
// Write-back / read-port bundle between the RV32I datapath and its register file.
interface regfile_wb_if #(
    parameter int N     = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [N-1:0]     wdata;
    logic [AW-1:0]    raddr1;
    logic [AW-1:0]    raddr2;
    logic [N-1:0]     rdata1;
    logic [N-1:0]     rdata2;
    logic [DEPTH-1:0] wsel;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, wsel
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, wsel
    );
endinterface

// File: rtl/regfile_wb_demux.sv
// 32-entry RV32I register file with one-hot write-back demux and two async read ports.
// Optional write-through bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_wb_cell #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] q
);
    logic [N-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (en) data_d = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign q = data_q;
endmodule

module regfile_wb_demux #(
    parameter int N     = 32,
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    regfile_wb_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] wsel;
    logic [N-1:0]     rf_view [DEPTH];
    logic [N-1:0]     rdata1, rdata2;

    // Slot 0 is x0: no cell behind it, hard-wired zero for the read muxes.
    assign rf_view[0] = '0;

    // Gating with rst_n keeps wsel quiet during reset, matching the lost write.
    always_comb begin
        wsel = '0;
        for (int i = 1; i < DEPTH; i++)
            wsel[i] = rst_n && bus.we && (bus.waddr == AW'(i));
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        regfile_wb_cell #(.N(N)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wsel[g]),
            .wdata (bus.wdata),
            .q     (rf_view[g])
        );
    end

    always_comb begin
        rdata1 = rf_view[bus.raddr1];
`ifdef REGFILE_BYPASS_EN
        if (bus.we && (bus.waddr != '0) && (bus.raddr1 == bus.waddr)) rdata1 = bus.wdata;
`endif
        if (!rst_n) rdata1 = '0;
    end

    always_comb begin
        rdata2 = rf_view[bus.raddr2];
`ifdef REGFILE_BYPASS_EN
        if (bus.we && (bus.waddr != '0) && (bus.raddr2 == bus.waddr)) rdata2 = bus.wdata;
`endif
        if (!rst_n) rdata2 = '0;
    end

    assign bus.rdata1 = rdata1;
    assign bus.rdata2 = rdata2;
    assign bus.wsel   = wsel;
endmodule

// File: doc/regfile_wb_demux.md
Name: regfile_wb_demux

Overview:
- 32-entry integer register file for the single-cycle RV32I core.
- The write-back path is an explicit one-hot demultiplexer: one N-bit write-back value is steered to exactly one register. This is the inverse of the write-back source mux.
- Two combinational read ports feed the ALU operand selection.
- Registers update on the rising clock edge; reads are combinational within the same cycle.

Parameters:
- N, 32, data width of each register and of every data port.
- DEPTH, 32, number of architectural registers. Fixed at 32 for RV32I; the address width is 5.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable from the control unit (RegWrite).
- waddr  input  5  destination register index (rd).
- wdata  input  N  write-back value from the write-back source mux.
- raddr1  input  5  source register 1 index (rs1).
- raddr2  input  5  source register 2 index (rs2).
- rdata1  output  N  value of register raddr1.
- rdata2  output  N  value of register raddr2.
- wsel  output  DEPTH  one-hot write-select vector (debug/verification visibility).

Behaviour:
- Reset:
  - rst_n low asynchronously clears registers x1..x31 to 0, regardless of clk.
  - While rst_n is low, rdata1 = rdata2 = 0 and wsel = 0.
  - Deassertion is sampled on the next rising edge; no write occurs on the edge where rst_n is still low.
- Write demux:
  - wsel[i] = we AND (waddr == i) for i = 1..31.
  - wsel[0] = 0 always.
  - At most one bit of wsel is high in any cycle.
  - On the rising edge with rst_n high and wsel[i] = 1, register i takes wdata.
  - All other registers hold their value.
- x0:
  - No storage.
  - Reads of index 0 return 0.
  - Writes to index 0 are discarded; wsel stays all-zero.
- Read ports:
  - Purely combinational; zero-cycle latency from the address or stored value.
  - rdata1 and rdata2 are independent, and both may address the same register.
- Write then read, same address, same cycle:
  - Without the optional feature, the read returns the OLD value.
  - The new value is visible the cycle after the edge.
- we low: no register changes and wsel = 0, whatever waddr and wdata are.
- Reset mid-operation: a pending write in the same cycle as rst_n falling is lost. Reset has priority.
- Width: wdata is stored unmodified. There is no sign extension or truncation inside the block.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass.
  - If we = 1, waddr != 0 and raddrK == waddr, then rdataK = wdata combinationally in the same cycle.
  - Applies to each read port independently.
  - x0 is never bypassed and still reads 0.
- Undefined: no bypass path; reads always return stored contents, as in Behaviour.

Test Plan:
- Reset clear:
  - Stimulus: preload x5 = 32'hDEADBEEF, then pulse rst_n low mid-cycle, asynchronously to clk.
  - Response: rdata1 (raddr1 = 5) reads 0 immediately, before the next edge.
- Basic write/read:
  - Stimulus: we = 1, waddr = 7, wdata = 32'h12345678 for one edge.
  - Response: wsel = 32'h00000080 during that cycle; afterwards raddr1 = 7 gives 32'h12345678 and raddr2 = 6 gives 0.
- x0 protection:
  - Stimulus: we = 1, waddr = 0, wdata = 32'hFFFFFFFF.
  - Response: wsel = 0; raddr1 = 0 gives 0 next cycle.
- Write disabled:
  - Stimulus: x3 = 32'hA5A5A5A5, then we = 0, waddr = 3, wdata = 32'h0.
  - Response: x3 still 32'hA5A5A5A5 and wsel = 0.
- Same-cycle read/write on x9 (old value 32'h1, new wdata = 32'h2):
  - With REGFILE_BYPASS_EN undefined, rdata1 = 32'h1 before the edge.
  - With it defined, rdata1 = 32'h2 before the edge.
  - In both builds, 32'h2 after the edge.
- Dual port / all registers:
  - Stimulus: write x(i) = i*32'h01010101 for i = 1..31.
  - Response: sweeping raddr1 = i and raddr2 = 31-i returns the matching values; raddr = 0 always gives 0.
